// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings: opcodes, immediate format enum and instruction field layouts.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    logic [11:0] imm11_0;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm11_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm4_0;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic       imm12;
    logic [5:0] imm10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm4_1;
    logic       imm11;
    logic [6:0] opcode;
  } b_type_t;

  typedef struct packed {
    logic [19:0] imm31_12;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef struct packed {
    logic       imm20;
    logic [9:0] imm10_1;
    logic       imm11;
    logic [7:0] imm19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_type_t;

  typedef union packed {
    i_type_t i;
    s_type_t s;
    b_type_t b;
    u_type_t u;
    j_type_t j;
  } instr_u;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word to extended immediate, format and illegal flag.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  instr_u      ins;
  logic [31:0] imm32;
  logic [5:0]  shamt;
  logic        use_shamt;
  logic        is_shift;

  assign ins      = instr_u'(instr_i);
  assign is_shift = (ins.i.funct3 == F3_SLL) || (ins.i.funct3 == F3_SRX);

  always_comb begin
    imm32     = '0;
    shamt     = '0;
    use_shamt = 1'b0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    unique case (ins.i.opcode)
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        fmt_o = FMT_I;
        imm32 = {{20{ins.i.imm11_0[11]}}, ins.i.imm11_0};
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          fmt_o     = FMT_SHAMT;
          use_shamt = 1'b1;
          if (XLEN == 32) begin
            shamt     = {1'b0, instr_i[24:20]};
            illegal_o = instr_i[25];
          end else begin
            shamt = instr_i[25:20];
          end
        end else begin
          fmt_o = FMT_I;
          imm32 = {{20{ins.i.imm11_0[11]}}, ins.i.imm11_0};
        end
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 32) begin
          illegal_o = 1'b1;
        end else if (is_shift) begin
          fmt_o     = FMT_SHAMT;
          use_shamt = 1'b1;
          shamt     = {1'b0, instr_i[24:20]};
          illegal_o = instr_i[25];
        end else begin
          fmt_o = FMT_I;
          imm32 = {{20{ins.i.imm11_0[11]}}, ins.i.imm11_0};
        end
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm32 = {{20{ins.s.imm11_5[6]}}, ins.s.imm11_5, ins.s.imm4_0};
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = {{19{ins.b.imm12}}, ins.b.imm12, ins.b.imm11, ins.b.imm10_5, ins.b.imm4_1, 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = {ins.u.imm31_12, 12'b0};
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm32 = {{11{ins.j.imm20}}, ins.j.imm20, ins.j.imm19_12, ins.j.imm11, ins.j.imm10_1, 1'b0};
      end
      OPC_OP: ;
      default: illegal_o = 1'b1;
    endcase
  end

  // Fill then overlay the low bits so one expression serves both XLEN=32 and 64.
  always_comb begin
    if (use_shamt) begin
      imm_o      = '0;
      imm_o[5:0] = shamt;
    end else begin
      imm_o       = {XLEN{imm32[31]}};
      imm_o[31:0] = imm32;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with main + skid entry; in_ready is a pure register output.
module imm_gen_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, dec_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept, main_free;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
  assign accept    = in_valid & in_ready_q;
  assign main_free = ~main_valid_q | out_ready;

  // in_ready_q always equals ~skid_valid_q outside reset, so accept never coincides with a full skid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec_entry;
      end
    end else if (accept) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share one input stream.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        r32_in_ready, r32_out_valid, r32_out_illegal;
  logic [31:0] r32_out_imm, r32_out_tag;
  logic [2:0]  r32_out_fmt;
  logic        r64_in_ready, r64_out_valid, r64_out_illegal;
  logic [63:0] r64_out_imm;
  logic [31:0] r64_out_tag;
  logic [2:0]  r64_out_fmt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_imm(r32_out_imm),
    .out_fmt(r32_out_fmt), .out_illegal(r32_out_illegal), .out_tag(r32_out_tag)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64_in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(r64_out_valid), .out_ready(out_ready), .out_imm(r64_out_imm),
    .out_fmt(r64_out_fmt), .out_illegal(r64_out_illegal), .out_tag(r64_out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " v32"},   64'(r32_out_valid), 64'd0);
    check({tag, " rdy32"}, 64'(r32_in_ready), 64'd0);
    check({tag, " imm32"}, 64'(r32_out_imm), 64'd0);
    check({tag, " fmt32"}, 64'(r32_out_fmt), 64'd0);
    check({tag, " ill32"}, 64'(r32_out_illegal), 64'd0);
    check({tag, " tag32"}, 64'(r32_out_tag), 64'd0);
    check({tag, " v64"},   64'(r64_out_valid), 64'd0);
    check({tag, " rdy64"}, 64'(r64_in_ready), 64'd0);
    check({tag, " imm64"}, r64_out_imm, 64'd0);
    check({tag, " tag64"}, 64'(r64_out_tag), 64'd0);
  endtask

  // One instruction through an empty stage with out_ready high; result visible right after the edge.
  task automatic send(input string tag, input logic [31:0] instr, input logic [31:0] t,
                      input logic [31:0] e_imm32, input logic [2:0] e_fmt32, input logic e_ill32,
                      input logic [63:0] e_imm64, input logic [2:0] e_fmt64, input logic e_ill64);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_tag    = t;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, " v32"},   64'(r32_out_valid), 64'd1);
    check({tag, " imm32"}, 64'(r32_out_imm), 64'(e_imm32));
    check({tag, " fmt32"}, 64'(r32_out_fmt), 64'(e_fmt32));
    check({tag, " ill32"}, 64'(r32_out_illegal), 64'(e_ill32));
    check({tag, " tag32"}, 64'(r32_out_tag), 64'(t));
    check({tag, " v64"},   64'(r64_out_valid), 64'd1);
    check({tag, " imm64"}, r64_out_imm, e_imm64);
    check({tag, " fmt64"}, 64'(r64_out_fmt), 64'(e_fmt64));
    check({tag, " ill64"}, 64'(r64_out_illegal), 64'(e_ill64));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_tag = '0;
    #1;
    check_reset_outputs("rst0");
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h55;
    step();
    step();
    check_reset_outputs("rst_hold");
    in_valid = 1'b0;
    rst = 1'b0;
    check("rdy_before_edge", 64'(r32_in_ready), 64'd0);
    step();
    check("rdy_after_rel32", 64'(r32_in_ready), 64'd1);
    check("rdy_after_rel64", 64'(r64_in_ready), 64'd1);

    // fmt codes: NONE 0, I 1, S 2, B 3, U 4, J 5, SHAMT 6
    send("addi", 32'hFFF00093, 32'h1000, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send("sw",   32'hFE112E23, 32'h1004, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    send("jal",  32'h001000EF, 32'h1008, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0);
    send("beq",  32'hFE000EE3, 32'h100C, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
    send("lui",  32'h800002B7, 32'h1010, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    send("slli33", 32'h02109093, 32'h1014, 32'h00000001, 3'd6, 1'b1, 64'd33, 3'd6, 1'b0);
    send("addiw", 32'h0010009B, 32'h1018, 32'h00000000, 3'd0, 1'b1, 64'd1, 3'd1, 1'b0);
    send("op",   32'h00000033, 32'h101C, 32'h00000000, 3'd0, 1'b0, 64'd0, 3'd0, 1'b0);
    send("opc7f", 32'h0000007F, 32'h1020, 32'h00000000, 3'd0, 1'b1, 64'd0, 3'd0, 1'b1);
    step();
    check("drain_empty", 64'(r32_out_valid), 64'd0);

    // Back-pressure: A in main, B in skid, C waits on the input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hA;
    step();
    check("bp_A_tag", 64'(r32_out_tag), 64'hA);
    check("bp_A_rdy", 64'(r32_in_ready), 64'd1);
    in_instr = 32'hFE112E23; in_tag = 32'hB;
    step();
    check("bp_B_tag", 64'(r32_out_tag), 64'hA);
    check("bp_B_rdy", 64'(r32_in_ready), 64'd0);
    in_instr = 32'h001000EF; in_tag = 32'hC;
    step();
    check("bp_hold_tag", 64'(r32_out_tag), 64'hA);
    check("bp_hold_imm", 64'(r32_out_imm), 64'hFFFFFFFF);
    check("bp_hold_rdy", 64'(r64_in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    check("bp_out_B_tag", 64'(r32_out_tag), 64'hB);
    check("bp_out_B_imm", r64_out_imm, 64'hFFFFFFFFFFFFFFFC);
    check("bp_out_B_fmt", 64'(r32_out_fmt), 64'd2);
    check("bp_out_B_rdy", 64'(r32_in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_out_C_tag", 64'(r32_out_tag), 64'hC);
    check("bp_out_C_imm", 64'(r32_out_imm), 64'h800);
    check("bp_out_C_v", 64'(r32_out_valid), 64'd1);
    step();
    check("bp_done_v", 64'(r32_out_valid), 64'd0);

    // Full throughput: one per cycle, skid never used.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'(100 + i);
      step();
      check("tp_tag", 64'(r32_out_tag), 64'(100 + i));
      check("tp_rdy", 64'(r32_in_ready), 64'd1);
      check("tp_imm", r64_out_imm, 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Flush with both entries full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'h21;
    step();
    in_tag = 32'h22;
    step();
    check("fl_pre_rdy", 64'(r32_in_ready), 64'd0);
    in_tag = 32'h23; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_v", 64'(r32_out_valid), 64'd0);
    check("fl_rdy", 64'(r32_in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("fl_after_v", 64'(r64_out_valid), 64'd0);

    // Flush beats a simultaneous capture into an empty stage.
    in_valid = 1'b1; in_tag = 32'h24; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_cap_v", 64'(r32_out_valid), 64'd0);
    step();
    check("fl_cap_v2", 64'(r32_out_valid), 64'd0);

    // Async reset mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h800002B7; in_tag = 32'h31;
    step();
    in_tag = 32'h32;
    step();
    check("mr_pre_v", 64'(r32_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mr");
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    check("mr_rdy_low", 64'(r32_in_ready), 64'd0);
    step();
    check("mr_rdy_rise", 64'(r32_in_ready), 64'd1);
    check("mr_v", 64'(r32_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered immediate-generation stage for the pipelined RISC-V core, between fetch and the decode/register-read stage. Takes a 32-bit instruction plus sideband tag over a valid/ready handshake. Outputs the fully sign- or zero-extended immediate at XLEN width, the instruction format, and an illegal-opcode flag. Holds one entry in a main register and one in a skid register, so the fetch side never sees a combinational ready path.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag carried with each instruction (normally the PC).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards every held entry.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage can accept; registered output.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  imm_fmt_e: NONE, I, S, B, U, J, SHAMT.
- out_illegal  out  1  opcode or shift encoding not legal for XLEN.
- out_tag  out  TAG_W  tag of the held entry.

## Operation
Opcode to format:
- I: LOAD 0000011, OP_IMM 0010011, JALR 1100111, MISC_MEM 0001111, SYSTEM 1110011.
- OP_IMM_32 0011011 decodes as I only when XLEN=64; otherwise illegal.
- S: STORE 0100011. B: BRANCH 1100011.
- U: LUI 0110111, AUIPC 0010111. J: JAL 1101111.
- NONE: OP 0110011, with imm = 0.
- Any other opcode: fmt NONE, imm = 0, illegal = 1. The block never outputs X.

Extension rules:
- I, S, B, J: sign-extend from instr[31] to XLEN.
- B and J: bit 0 of the immediate is 0.
- U: {instr[31:12], 12'b0}, sign-extended to XLEN.

Shift-immediates (OP_IMM or OP_IMM_32 with funct3 001 or 101):
- fmt SHAMT; imm = zero-extended shamt.
- shamt is instr[24:20] when XLEN=32 or for OP_IMM_32, and instr[25:20] when XLEN=64.
- XLEN=32 or OP_IMM_32 with instr[25]=1: illegal = 1.

Handshake:
- A transfer occurs on any edge where valid and ready are both high.
- While out_valid=1 and out_ready=0, all out_* are held stable.
- Input accepted while the main register is full and not draining goes to the skid register.
- in_ready = NOT skid_valid, registered; it is 0 on the cycle after the skid fills.
- When the main register drains, it loads from the skid first if the skid is valid; otherwise from the input.
- Entries leave in arrival order, with no loss and no duplication.

Flush:
- At the next edge, clears main_valid and skid_valid and sets in_ready=1.
- Flush has priority over a simultaneous input capture; that input is dropped.

## Timing
- Reset values: out_valid=0, in_ready=0, out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0, skid empty.
- in_ready rises on the first edge after rst deasserts. No transfer occurs while rst is high.
- Reset asserted mid-stream clears both entries immediately, asynchronously.
- Latency is 1 cycle: an instruction accepted at edge N is presented from edge N onward, visible in cycle N+1.
- Full-throughput case (out_ready held 1): one instruction per cycle; skid stays empty.
- Simultaneous drain and accept with the skid full: the main register takes the skid entry, and the skid takes nothing because in_ready was 0.

## Structure
- Shared package riscv_pkg holds:
  - opcode localparams;
  - imm_fmt_e (3-bit enum);
  - I/S/B/U/J packed instruction structs, used for field extraction.
- Sub-module imm_decode: purely combinational, parametrised by XLEN, mapping instr to {imm, fmt, illegal}. It is instantiated once on the input side; its results are registered through the skid logic.

## Test plan
- XLEN=32. Send addi x1,x0,-1 (0xFFF00093) -> next cycle out_imm=0xFFFFFFFF, fmt I, illegal 0.
- Send sw x1,-4(x2) (0xFE112E23) -> out_imm=0xFFFFFFFC, fmt S. Send jal x1,+2048 (0x001000EF) -> out_imm=0x00000800, fmt J.
- XLEN=64. Send lui x5,0x80000 (0x800002B7) -> out_imm=0xFFFFFFFF80000000, fmt U. Send slli with shamt 33 -> fmt SHAMT, imm=33, illegal 0. Under XLEN=32 the same word -> illegal 1.
- Opcode 0x7F -> illegal=1, imm=0, fmt NONE.
- Back-pressure: out_ready=0 while streaming tags A,B,C.
  - A is held in the main register and B in the skid; in_ready=0 and C stays on the input.
  - out_ready=1 -> outputs A,B,C on consecutive accepts, in order, no duplicates.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, input dropped.
- rst pulsed mid-stream -> all outputs return to reset values immediately; in_ready rises on the first edge after release.
